dram_sc_rep_pipe: RTL and testbench

- Parametrised, retimed successor to the flat DRAM<->L2 (sctag/scbuf) repeater column.
- Inserts a configurable number of flop stages per direction. Data buses load only when their qualifying valid is active.
- Adds outstanding read/write request tracking and read-chunk sequence checking, with sticky error flags for debug.
- Sits between the DRAM controller and the L2 bank pair, pin-ordered as the existing repeater column.

---
 rtl/dram_sc_rep_pkg.sv | 24 ++
 rtl/dram_sc_rep_stage.sv | 72 +++++++
 rtl/dram_sc_rep_pipe.sv | 236 +++++++++++++++++++++++
 tb/tb_dram_sc_rep_pipe.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_sc_rep_pkg.sv
// ---------------------------------------------------------------------------
// dram_sc_rep_pkg
// Shared constants for the retimed DRAM <-> L2 repeater column.
//   CHUNKS_PER_LINE / LAST_CHUNK : a read line returns as four chunks, 0..3
//   ERR_*                        : bit positions inside rep_err
//   MAX_STAGES                   : deepest flop chain a direction may use
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

package dram_sc_rep_pkg;

    localparam int          CHUNKS_PER_LINE = 4;
    localparam logic [1:0]  LAST_CHUNK      = 2'd3;

    localparam int          REP_ERR_W  = 5;
    localparam int          ERR_RD_OVF = 0;
    localparam int          ERR_RD_UNF = 1;
    localparam int          ERR_WR_OVF = 2;
    localparam int          ERR_WR_UNF = 3;
    localparam int          ERR_CHUNK  = 4;

    localparam int          MAX_STAGES = 4;

endpackage

// File: rtl/dram_sc_rep_stage.sv
// ---------------------------------------------------------------------------
// dram_sc_rep_stage
// N-deep, enable-qualified flop chain. The enable travels down the chain
// next to the data, so every stage loads only when its own delayed copy of
// the enable is high and otherwise holds. N = 0 collapses to a wire.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   en       : load qualifier that accompanies d
//   d        : W-bit data into the first stage
//   q        : W-bit data out of the last stage
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module dram_sc_rep_stage #(
    parameter int W = 1,
    parameter int N = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    if (N == 0) begin : g_wire
        assign q = d;
    end else begin : g_pipe
        logic [W-1:0] data_q [N];
        logic [N-1:0] stage_en;

        if (N == 1) begin : g_en_single
            assign stage_en = en;
        end else begin : g_en_chain
            logic [N-2:0] en_q;

            assign stage_en = {en_q, en};

            // Enable copies follow the data unconditionally, one stage per
            // clock, so stage i sees the qualifier that belonged to the
            // value now sitting in stage i-1.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    en_q <= '0;
                end else begin
                    en_q <= stage_en[N-2:0];
                end
            end
        end

        // Each stage copies its predecessor only when the matching enable
        // copy is set; otherwise it keeps the last qualified value.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < N; i++) begin
                    data_q[i] <= '0;
                end
            end else begin
                if (stage_en[0]) begin
                    data_q[0] <= d;
                end
                for (int i = 1; i < N; i++) begin
                    if (stage_en[i]) begin
                        data_q[i] <= data_q[i-1];
                    end
                end
            end
        end

        assign q = data_q[N-1];
    end

endmodule

// File: rtl/dram_sc_rep_pipe.sv
// ---------------------------------------------------------------------------
// dram_sc_rep_pipe
// Retimed repeater column between the DRAM controller and the L2 bank pair.
// Every dram->sc signal is delayed DN_STAGES clocks and every sc->dram
// signal UP_STAGES clocks. Wide data buses load only when qualified.
// Outstanding read/write trackers and a read-chunk sequence checker watch
// the raw inputs and report problems through sticky rep_err bits.
// Ports:
//   rclk, arst          : clock, asynchronous active-high reset
//   <signal> -> <signal>_buf : repeated dram->sc and sc->dram signals
//   err_clr             : clears rep_err (new events in the same cycle win)
//   rd_outst, wr_outst  : outstanding read lines / unacked writes
//   rep_err             : [0] rd ovf [1] rd unf [2] wr ovf [3] wr unf
//                         [4] chunk sequence error
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module dram_sc_rep_pipe
    import dram_sc_rep_pkg::*;
#(
    parameter int DN_STAGES = 1,
    parameter int UP_STAGES = 1,
    parameter int DATA_W    = 128,
    parameter int ECC_W     = 28,
    parameter int WDATA_W   = 64,
    parameter int MAX_OUTST = 8,
    localparam int CNT_W    = $clog2(MAX_OUTST + 1)
) (
    input  logic               rclk,
    input  logic               arst,

    input  logic [DATA_W-1:0]  dram_scbuf_data_r2,
    output logic [DATA_W-1:0]  dram_scbuf_data_r2_buf,
    input  logic [ECC_W-1:0]   dram_scbuf_ecc_r2,
    output logic [ECC_W-1:0]   dram_scbuf_ecc_r2_buf,

    input  logic [WDATA_W-1:0] scbuf_dram_wr_data_r5,
    output logic [WDATA_W-1:0] scbuf_dram_wr_data_r5_buf,
    input  logic               scbuf_dram_data_vld_r5,
    output logic               scbuf_dram_data_vld_r5_buf,
    input  logic               scbuf_dram_data_mecc_r5,
    output logic               scbuf_dram_data_mecc_r5_buf,

    input  logic               sctag_dram_rd_req,
    output logic               sctag_dram_rd_req_buf,
    input  logic               sctag_dram_rd_dummy_req,
    output logic               sctag_dram_rd_dummy_req_buf,
    input  logic               sctag_dram_wr_req,
    output logic               sctag_dram_wr_req_buf,
    input  logic [2:0]         sctag_dram_rd_req_id,
    output logic [2:0]         sctag_dram_rd_req_id_buf,
    input  logic [39:5]        sctag_dram_addr,
    output logic [39:5]        sctag_dram_addr_buf,

    input  logic               dram_sctag_rd_ack,
    output logic               dram_sctag_rd_ack_buf,
    input  logic               dram_sctag_wr_ack,
    output logic               dram_sctag_wr_ack_buf,
    input  logic               dram_sctag_data_vld_r0,
    output logic               dram_sctag_data_vld_r0_buf,
    input  logic [1:0]         dram_sctag_chunk_id_r0,
    output logic [1:0]         dram_sctag_chunk_id_r0_buf,
    input  logic [2:0]         dram_sctag_rd_req_id_r0,
    output logic [2:0]         dram_sctag_rd_req_id_r0_buf,
    input  logic               dram_sctag_secc_err_r2,
    output logic               dram_sctag_secc_err_r2_buf,
    input  logic               dram_sctag_mecc_err_r2,
    output logic               dram_sctag_mecc_err_r2_buf,
    input  logic               dram_sctag_scb_secc_err,
    output logic               dram_sctag_scb_secc_err_buf,
    input  logic               dram_sctag_scb_mecc_err,
    output logic               dram_sctag_scb_mecc_err_buf,

    input  logic               err_clr,
    output logic [CNT_W-1:0]   rd_outst,
    output logic [CNT_W-1:0]   wr_outst,
    output logic [REP_ERR_W-1:0] rep_err
);

    localparam int DN_CTL_W = 12;
    localparam int UP_CTL_W = 3;
    localparam int UP_ADR_W = 35 + 3 + 1;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTST);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // ------------------------------------------------------------------
    // dram -> sc direction
    // ------------------------------------------------------------------
    logic                vld_r1;
    logic                vld_r2;
    logic [DN_CTL_W-1:0] dn_ctl_out;

    // Read data trails data_vld_r0 by two clocks, so a local r0->r2 shadow
    // of the valid produces the qualifier for the read data/ECC chain.
    always_ff @(posedge rclk or posedge arst) begin
        if (arst) begin
            vld_r1 <= 1'b0;
            vld_r2 <= 1'b0;
        end else begin
            vld_r1 <= dram_sctag_data_vld_r0;
            vld_r2 <= vld_r1;
        end
    end

    dram_sc_rep_stage #(.W(DATA_W + ECC_W), .N(DN_STAGES)) u_dn_rdata (
        .clk (rclk),
        .rst (arst),
        .en  (vld_r2),
        .d   ({dram_scbuf_data_r2, dram_scbuf_ecc_r2}),
        .q   ({dram_scbuf_data_r2_buf, dram_scbuf_ecc_r2_buf})
    );

    dram_sc_rep_stage #(.W(DN_CTL_W), .N(DN_STAGES)) u_dn_ctl (
        .clk (rclk),
        .rst (arst),
        .en  (1'b1),
        .d   ({dram_sctag_rd_ack, dram_sctag_wr_ack, dram_sctag_data_vld_r0,
               dram_sctag_chunk_id_r0, dram_sctag_rd_req_id_r0,
               dram_sctag_secc_err_r2, dram_sctag_mecc_err_r2,
               dram_sctag_scb_secc_err, dram_sctag_scb_mecc_err}),
        .q   (dn_ctl_out)
    );

    assign {dram_sctag_rd_ack_buf, dram_sctag_wr_ack_buf, dram_sctag_data_vld_r0_buf,
            dram_sctag_chunk_id_r0_buf, dram_sctag_rd_req_id_r0_buf,
            dram_sctag_secc_err_r2_buf, dram_sctag_mecc_err_r2_buf,
            dram_sctag_scb_secc_err_buf, dram_sctag_scb_mecc_err_buf} = dn_ctl_out;

    // ------------------------------------------------------------------
    // sc -> dram direction
    // ------------------------------------------------------------------
    logic                any_req;

    assign any_req = sctag_dram_rd_req | sctag_dram_rd_dummy_req | sctag_dram_wr_req;

    dram_sc_rep_stage #(.W(WDATA_W + 1), .N(UP_STAGES)) u_up_wdata (
        .clk (rclk),
        .rst (arst),
        .en  (scbuf_dram_data_vld_r5),
        .d   ({scbuf_dram_wr_data_r5, scbuf_dram_data_mecc_r5}),
        .q   ({scbuf_dram_wr_data_r5_buf, scbuf_dram_data_mecc_r5_buf})
    );

    dram_sc_rep_stage #(.W(UP_CTL_W), .N(UP_STAGES)) u_up_ctl (
        .clk (rclk),
        .rst (arst),
        .en  (1'b1),
        .d   ({scbuf_dram_data_vld_r5, sctag_dram_rd_req, sctag_dram_wr_req}),
        .q   ({scbuf_dram_data_vld_r5_buf, sctag_dram_rd_req_buf, sctag_dram_wr_req_buf})
    );

    // The dummy flag rides with address/id: it only carries meaning in the
    // cycle a request strobe accompanies it.
    dram_sc_rep_stage #(.W(UP_ADR_W), .N(UP_STAGES)) u_up_addr (
        .clk (rclk),
        .rst (arst),
        .en  (any_req),
        .d   ({sctag_dram_addr, sctag_dram_rd_req_id, sctag_dram_rd_dummy_req}),
        .q   ({sctag_dram_addr_buf, sctag_dram_rd_req_id_buf, sctag_dram_rd_dummy_req_buf})
    );

    // ------------------------------------------------------------------
    // Trackers (watch raw inputs, so stage depth never affects counts)
    // ------------------------------------------------------------------
    logic             rd_inc, rd_dec, wr_inc, wr_dec;
    logic [CNT_W-1:0] rd_cnt_nxt, wr_cnt_nxt;
    logic             rd_ovf, rd_unf, wr_ovf, wr_unf;
    logic             chunk_err;
    logic [1:0]       exp_chunk;
    logic [REP_ERR_W-1:0] err_set;

    assign rd_inc    = sctag_dram_rd_req;
    assign rd_dec    = dram_sctag_data_vld_r0 && (dram_sctag_chunk_id_r0 == LAST_CHUNK);
    assign wr_inc    = sctag_dram_wr_req;
    assign wr_dec    = dram_sctag_wr_ack;
    assign chunk_err = dram_sctag_data_vld_r0 && (dram_sctag_chunk_id_r0 != exp_chunk);

    // Next outstanding counts. Simultaneous inc/dec cancel; an inc at the
    // limit or a dec at zero leaves the count alone and flags an error.
    always_comb begin
        rd_cnt_nxt = rd_outst;
        rd_ovf     = 1'b0;
        rd_unf     = 1'b0;
        if (rd_inc && !rd_dec) begin
            if (rd_outst == CNT_MAX) rd_ovf = 1'b1;
            else                     rd_cnt_nxt = rd_outst + CNT_ONE;
        end else if (rd_dec && !rd_inc) begin
            if (rd_outst == '0)      rd_unf = 1'b1;
            else                     rd_cnt_nxt = rd_outst - CNT_ONE;
        end

        wr_cnt_nxt = wr_outst;
        wr_ovf     = 1'b0;
        wr_unf     = 1'b0;
        if (wr_inc && !wr_dec) begin
            if (wr_outst == CNT_MAX) wr_ovf = 1'b1;
            else                     wr_cnt_nxt = wr_outst + CNT_ONE;
        end else if (wr_dec && !wr_inc) begin
            if (wr_outst == '0)      wr_unf = 1'b1;
            else                     wr_cnt_nxt = wr_outst - CNT_ONE;
        end
    end

    // Gather this cycle's error events into rep_err bit positions.
    always_comb begin
        err_set             = '0;
        err_set[ERR_RD_OVF] = rd_ovf;
        err_set[ERR_RD_UNF] = rd_unf;
        err_set[ERR_WR_OVF] = wr_ovf;
        err_set[ERR_WR_UNF] = wr_unf;
        err_set[ERR_CHUNK]  = chunk_err;
    end

    // Counter, chunk-expectation and sticky error state. On every valid
    // chunk the next expectation is chunk_id+1: on a match that equals
    // exp_chunk+1, and on a mismatch it is the resync value. err_clr drops
    // old bits but a new event in the same cycle still lands.
    always_ff @(posedge rclk or posedge arst) begin
        if (arst) begin
            rd_outst  <= '0;
            wr_outst  <= '0;
            exp_chunk <= 2'd0;
            rep_err   <= '0;
        end else begin
            rd_outst <= rd_cnt_nxt;
            wr_outst <= wr_cnt_nxt;
            if (dram_sctag_data_vld_r0) begin
                exp_chunk <= dram_sctag_chunk_id_r0 + 2'd1;
            end
            if (err_clr) rep_err <= err_set;
            else         rep_err <= rep_err | err_set;
        end
    end

endmodule

// File: tb/tb_dram_sc_rep_pipe.sv
// ---------------------------------------------------------------------------
// tb_dram_sc_rep_pipe
// Directed bench for dram_sc_rep_pipe with DN_STAGES=2, UP_STAGES=1 and
// MAX_OUTST=3 (2-bit counters). Inputs change 1 ns after a rising edge and
// outputs are sampled at the same point, so a value shown after edge k
// reflects state loaded on edge k.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_dram_sc_rep_pipe;

    logic         rclk;
    logic         arst;
    logic [127:0] data_r2;
    logic [127:0] data_r2_buf;
    logic [27:0]  ecc_r2;
    logic [27:0]  ecc_r2_buf;
    logic [63:0]  wr_data;
    logic [63:0]  wr_data_buf;
    logic         wr_vld, wr_vld_buf, wr_mecc, wr_mecc_buf;
    logic         rd_req, rd_req_buf, dummy_req, dummy_req_buf, wr_req, wr_req_buf;
    logic [2:0]   req_id, req_id_buf;
    logic [39:5]  addr, addr_buf;
    logic         rd_ack, rd_ack_buf, wr_ack, wr_ack_buf, data_vld, data_vld_buf;
    logic [1:0]   chunk_id, chunk_id_buf;
    logic [2:0]   ret_id, ret_id_buf;
    logic         secc, secc_buf, mecc, mecc_buf, scb_secc, scb_secc_buf, scb_mecc, scb_mecc_buf;
    logic         err_clr;
    logic [1:0]   rd_outst, wr_outst;
    logic [4:0]   rep_err;

    int total;
    int bad;

    dram_sc_rep_pipe #(
        .DN_STAGES (2),
        .UP_STAGES (1),
        .DATA_W    (128),
        .ECC_W     (28),
        .WDATA_W   (64),
        .MAX_OUTST (3)
    ) dut (
        .rclk                        (rclk),
        .arst                        (arst),
        .dram_scbuf_data_r2          (data_r2),
        .dram_scbuf_data_r2_buf      (data_r2_buf),
        .dram_scbuf_ecc_r2           (ecc_r2),
        .dram_scbuf_ecc_r2_buf       (ecc_r2_buf),
        .scbuf_dram_wr_data_r5       (wr_data),
        .scbuf_dram_wr_data_r5_buf   (wr_data_buf),
        .scbuf_dram_data_vld_r5      (wr_vld),
        .scbuf_dram_data_vld_r5_buf  (wr_vld_buf),
        .scbuf_dram_data_mecc_r5     (wr_mecc),
        .scbuf_dram_data_mecc_r5_buf (wr_mecc_buf),
        .sctag_dram_rd_req           (rd_req),
        .sctag_dram_rd_req_buf       (rd_req_buf),
        .sctag_dram_rd_dummy_req     (dummy_req),
        .sctag_dram_rd_dummy_req_buf (dummy_req_buf),
        .sctag_dram_wr_req           (wr_req),
        .sctag_dram_wr_req_buf       (wr_req_buf),
        .sctag_dram_rd_req_id        (req_id),
        .sctag_dram_rd_req_id_buf    (req_id_buf),
        .sctag_dram_addr             (addr),
        .sctag_dram_addr_buf         (addr_buf),
        .dram_sctag_rd_ack           (rd_ack),
        .dram_sctag_rd_ack_buf       (rd_ack_buf),
        .dram_sctag_wr_ack           (wr_ack),
        .dram_sctag_wr_ack_buf       (wr_ack_buf),
        .dram_sctag_data_vld_r0      (data_vld),
        .dram_sctag_data_vld_r0_buf  (data_vld_buf),
        .dram_sctag_chunk_id_r0      (chunk_id),
        .dram_sctag_chunk_id_r0_buf  (chunk_id_buf),
        .dram_sctag_rd_req_id_r0     (ret_id),
        .dram_sctag_rd_req_id_r0_buf (ret_id_buf),
        .dram_sctag_secc_err_r2      (secc),
        .dram_sctag_secc_err_r2_buf  (secc_buf),
        .dram_sctag_mecc_err_r2      (mecc),
        .dram_sctag_mecc_err_r2_buf  (mecc_buf),
        .dram_sctag_scb_secc_err     (scb_secc),
        .dram_sctag_scb_secc_err_buf (scb_secc_buf),
        .dram_sctag_scb_mecc_err     (scb_mecc),
        .dram_sctag_scb_mecc_err_buf (scb_mecc_buf),
        .err_clr                     (err_clr),
        .rd_outst                    (rd_outst),
        .wr_outst                    (wr_outst),
        .rep_err                     (rep_err)
    );

    // Free-running 100 MHz clock.
    initial begin
        rclk = 1'b0;
        forever #5 rclk = ~rclk;
    end

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    // Drive every data/control input to one value (0 or all ones).
    task automatic apply_stimulus(input logic val);
        data_r2   = {128{val}};
        ecc_r2    = {28{val}};
        wr_data   = {64{val}};
        wr_vld    = val;
        wr_mecc   = val;
        rd_req    = val;
        dummy_req = val;
        wr_req    = val;
        req_id    = {3{val}};
        addr      = {35{val}};
        rd_ack    = val;
        wr_ack    = val;
        data_vld  = val;
        chunk_id  = {2{val}};
        ret_id    = {3{val}};
        secc      = val;
        mecc      = val;
        scb_secc  = val;
        scb_mecc  = val;
        err_clr   = val;
    endtask

    // One comparison: count it, and on a miss count and report it.
    task automatic check_output(input string tag, input logic [127:0] obs,
                                input logic [127:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Directed sequence: reset, latency, read tracking and burst, write
    // overflow/underflow, chunk resync, reset in the middle of a burst.
    initial begin
        total = 0;
        bad   = 0;

        // Reset with every input held high: all outputs stay 0.
        arst = 1'b1;
        apply_stimulus(1'b1);
        tick();
        tick();
        check_output("rst_data_buf",   128'(data_r2_buf), 128'h0);
        check_output("rst_ecc_buf",    128'(ecc_r2_buf),  128'h0);
        check_output("rst_wdata_buf",  128'(wr_data_buf), 128'h0);
        check_output("rst_rd_ack_buf", 128'(rd_ack_buf),  128'h0);
        check_output("rst_wr_req_buf", 128'(wr_req_buf),  128'h0);
        check_output("rst_addr_buf",   128'(addr_buf),    128'h0);
        check_output("rst_rd_outst",   128'(rd_outst),    128'h0);
        check_output("rst_wr_outst",   128'(wr_outst),    128'h0);
        check_output("rst_rep_err",    128'(rep_err),     128'h0);

        apply_stimulus(1'b0);
        tick();
        arst = 1'b0;
        $display("[TB] reset released");

        // Latency: wr_req_buf one clock, rd_ack_buf two clocks.
        rd_ack = 1'b1;
        wr_req = 1'b1;
        tick();
        check_output("lat_wr_req_1", 128'(wr_req_buf), 128'h1);
        check_output("lat_rd_ack_1", 128'(rd_ack_buf), 128'h0);
        check_output("wr_outst_inc", 128'(wr_outst),   128'h1);
        wr_req = 1'b0;
        tick();
        check_output("lat_rd_ack_2", 128'(rd_ack_buf), 128'h1);
        check_output("lat_wr_req_2", 128'(wr_req_buf), 128'h0);
        rd_ack = 1'b0;
        wr_ack = 1'b1;
        tick();
        check_output("wr_outst_ack", 128'(wr_outst), 128'h0);
        wr_ack = 1'b0;

        // Three reads with addresses, then a dummy, then an idle cycle.
        rd_req = 1'b1;
        addr = 35'h123;
        tick();
        check_output("rd_outst_1", 128'(rd_outst), 128'h1);
        check_output("addr_1",     128'(addr_buf), 128'h123);
        addr = 35'h456;
        tick();
        check_output("rd_outst_2", 128'(rd_outst), 128'h2);
        addr = 35'h789;
        tick();
        check_output("rd_outst_3", 128'(rd_outst), 128'h3);
        check_output("addr_3",     128'(addr_buf), 128'h789);
        rd_req    = 1'b0;
        dummy_req = 1'b1;
        addr      = 35'h0AB;
        tick();
        check_output("dummy_rd_outst", 128'(rd_outst), 128'h3);
        check_output("dummy_addr",     128'(addr_buf), 128'h0AB);
        dummy_req = 1'b0;
        addr      = 35'h555;
        tick();
        check_output("addr_hold", 128'(addr_buf), 128'h0AB);

        // Read burst: vld on cycles 0..3, data 0xA..0xD on cycles 2..5,
        // garbage elsewhere. With two stages, data from cycle k shows after
        // edge k+1, and the chunk-3 cycle drops rd_outst to 2.
        for (int k = 0; k < 8; k++) begin
            data_vld = (k < 4);
            chunk_id = 2'(k);
            if (k >= 2 && k < 6) begin
                data_r2 = 128'(10 + k - 2);
                ecc_r2  = 28'(10 + k - 2);
            end else begin
                data_r2 = {4{32'hDEADBEEF}};
                ecc_r2  = 28'hBADBEEF;
            end
            tick();
            check_output($sformatf("burst_data_%0d", k), data_r2_buf,
                         (k < 3) ? 128'h0 : (k <= 6) ? 128'(10 + k - 3) : 128'hD);
            check_output($sformatf("burst_rd_outst_%0d", k), 128'(rd_outst),
                         (k < 3) ? 128'h3 : 128'h2);
            if (k >= 1 && k <= 4) begin
                check_output($sformatf("burst_chunk_buf_%0d", k), 128'(chunk_id_buf),
                             128'(k - 1));
            end
        end
        data_vld = 1'b0;
        check_output("burst_ecc_buf", 128'(ecc_r2_buf), 128'hD);
        check_output("burst_rep_err", 128'(rep_err),    128'h0);

        // Write data only loads with vld_r5; four writes overflow limit 3.
        wr_req  = 1'b1;
        wr_vld  = 1'b1;
        wr_data = 64'h1111_2222_3333_4444;
        wr_mecc = 1'b1;
        tick();
        check_output("wdata_load",  128'(wr_data_buf), 128'h1111_2222_3333_4444);
        check_output("wmecc_load",  128'(wr_mecc_buf), 128'h1);
        check_output("wr_outst_w1", 128'(wr_outst),    128'h1);
        wr_vld  = 1'b0;
        wr_data = 64'hFFFF_FFFF_FFFF_FFFF;
        wr_mecc = 1'b0;
        tick();
        check_output("wdata_hold",  128'(wr_data_buf), 128'h1111_2222_3333_4444);
        check_output("wmecc_hold",  128'(wr_mecc_buf), 128'h1);
        check_output("wr_outst_w2", 128'(wr_outst),    128'h2);
        tick();
        check_output("wr_outst_w3", 128'(wr_outst), 128'h3);
        check_output("no_ovf_yet",  128'(rep_err),  128'h0);
        tick();
        check_output("wr_outst_sat", 128'(wr_outst), 128'h3);
        check_output("wr_ovf_err",   128'(rep_err),  128'h04);
        wr_req  = 1'b0;
        wr_ack  = 1'b1;
        err_clr = 1'b1;
        tick();
        check_output("ack_clr_outst", 128'(wr_outst), 128'h2);
        check_output("ack_clr_err",   128'(rep_err),  128'h0);
        err_clr = 1'b0;
        tick();
        tick();
        check_output("wr_outst_zero", 128'(wr_outst), 128'h0);
        err_clr = 1'b1;
        tick();
        check_output("unf_hold_outst", 128'(wr_outst), 128'h0);
        check_output("unf_beats_clr",  128'(rep_err),  128'h08);
        wr_ack = 1'b0;
        tick();
        check_output("clr_only", 128'(rep_err), 128'h0);
        err_clr = 1'b0;

        // Chunk order 0,1,3,0: error on the 3, resync makes the 0 legal.
        data_vld = 1'b1;
        chunk_id = 2'd0;
        tick();
        chunk_id = 2'd1;
        tick();
        check_output("seq_ok_01", 128'(rep_err), 128'h0);
        chunk_id = 2'd3;
        tick();
        check_output("seq_err_3",    128'(rep_err),  128'h10);
        check_output("seq_rd_outst", 128'(rd_outst), 128'h1);
        chunk_id = 2'd0;
        tick();
        check_output("seq_resync_0", 128'(rep_err), 128'h10);
        data_vld = 1'b0;
        err_clr  = 1'b1;
        tick();
        err_clr  = 1'b0;
        data_vld = 1'b1;
        chunk_id = 2'd1;
        tick();
        check_output("seq_resync_1", 128'(rep_err), 128'h0);
        chunk_id = 2'd2;
        tick();
        chunk_id = 2'd3;
        tick();
        check_output("seq_tail_err",    128'(rep_err),  128'h0);
        check_output("seq_tail_outst",  128'(rd_outst), 128'h0);
        data_vld = 1'b0;

        // Start a new burst, then reset after chunk 1.
        rd_req = 1'b1;
        wr_req = 1'b1;
        tick();
        rd_req   = 1'b0;
        wr_req   = 1'b0;
        data_vld = 1'b1;
        chunk_id = 2'd0;
        data_r2  = 128'h77;
        tick();
        chunk_id = 2'd1;
        tick();
        check_output("pre_rst_rd_outst", 128'(rd_outst), 128'h1);
        check_output("pre_rst_wr_outst", 128'(wr_outst), 128'h1);
        arst = 1'b1;
        #1;
        check_output("mid_rst_rd_outst", 128'(rd_outst),    128'h0);
        check_output("mid_rst_wr_outst", 128'(wr_outst),    128'h0);
        check_output("mid_rst_data_buf", data_r2_buf,       128'h0);
        check_output("mid_rst_vld_buf",  128'(data_vld_buf), 128'h0);
        check_output("mid_rst_rep_err",  128'(rep_err),     128'h0);
        apply_stimulus(1'b0);
        tick();
        arst = 1'b0;

        // Fresh burst after reset: expectation restarts at chunk 0.
        rd_req = 1'b1;
        tick();
        check_output("post_rst_rd_outst", 128'(rd_outst), 128'h1);
        rd_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            data_vld = 1'b1;
            chunk_id = 2'(k);
            tick();
        end
        data_vld = 1'b0;
        check_output("post_rst_err",   128'(rep_err),  128'h0);
        check_output("post_rst_outst", 128'(rd_outst), 128'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
